// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V sequencer: opcodes, state
// encoding, ALU class codes and the one-hot opcode class.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic r;
        logic ialu;
        logic load;
        logic store;
        logic branch;
        logic invalid;
    } op_class_t;

endpackage

// File: rtl/mc_op_class.sv
// Combinational opcode classifier: 7-bit opcode to a one-hot instruction class.
module mc_op_class
    import ctrl_pkg::*;
(
    input  logic [6:0] op_code,
    output op_class_t  op_class
);

    always_comb begin
        // NOTE: default every field first so no path leaves a latch behind.
        op_class = '0;
        case (op_code)
            OP_R:      op_class.r       = 1'b1;
            OP_IALU:   op_class.ialu    = 1'b1;
            OP_LOAD:   op_class.load    = 1'b1;
            OP_STORE:  op_class.store   = 1'b1;
            OP_BRANCH: op_class.branch  = 1'b1;
            default:   op_class.invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with sticky illegal/timeout trap.
// Optional performance counters (instret, cycles) when MC_CTRL_PERF_EN is defined.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_code,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       alu_src,
    output logic       reg_write_en,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instret,
    output logic [31:0] cycles
`endif
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t           state_q;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [6:0]       class_op;
    op_class_t        cls;
    logic             limit_hit;

    // DECODE classifies the live opcode; later states use the latched one.
    assign class_op  = (state_q == ST_DECODE) ? op_code : op_q;
    assign limit_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
    assign state     = state_q;

    mc_op_class u_op_class (
        .op_code  (class_op),
        .op_class (cls)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_q  <= ST_DECODE;
                        wait_cnt <= '0;
                    end else if (limit_hit) begin
                        state_q  <= ST_TRAP;
                        timeout  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    op_q <= op_code;
                    if (cls.invalid) begin
                        state_q <= ST_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cls.load || cls.store) state_q <= ST_MEM;
                    else if (cls.branch)       state_q <= ST_FETCH;
                    else                       state_q <= ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state_q  <= cls.load ? ST_WB : ST_FETCH;
                        wait_cnt <= '0;
                    end else if (limit_hit) begin
                        state_q  <= ST_TRAP;
                        timeout  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_WB:   state_q <= ST_FETCH;
                ST_TRAP: state_q <= ST_TRAP;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        mem_read     = 1'b0;
        mem_to_reg   = 1'b0;
        mem_write    = 1'b0;
        alu_src      = 1'b0;
        reg_write_en = 1'b0;
        alu_op       = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            ST_EXEC: begin
                if (cls.r) begin
                    alu_op = ALU_FUNCT;
                end else if (cls.branch) begin
                    branch = 1'b1;
                    alu_op = ALU_BRANCH;
                end else begin
                    alu_src = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                alu_src      = 1'b1;
                mem_read     = cls.load;
                mem_write    = cls.store;
            end
            ST_WB: begin
                reg_write_en = 1'b1;
                mem_to_reg   = cls.load;
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic retire;

    // An instruction retires when control returns to FETCH from EXEC, MEM or WB.
    assign retire = (state_q == ST_WB)
                 || (state_q == ST_EXEC && cls.branch)
                 || (state_q == ST_MEM && mem_ready && cls.store);

    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
            cycles  <= '0;
        end else begin
            if (state_q != ST_TRAP) cycles <= cycles + 32'd1;
            if (retire) instret <= instret + 32'd1;
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with MEM_TIMEOUT=4; perf counter
// checks are included when MC_CTRL_PERF_EN is defined.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [6:0] op_code;
    logic       mem_ready;
    logic       mem_req, mem_addr_sel, ir_write, pc_write, branch, mem_read;
    logic       mem_to_reg, mem_write, alu_src, reg_write_en;
    logic [1:0] alu_op;
    logic       illegal, timeout;
    logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] instret, cycles;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    // ctl = {mem_req, mem_addr_sel, ir_write, pc_write, branch, mem_read,
    //        mem_to_reg, mem_write, alu_src, reg_write_en, alu_op[1:0]}
    localparam logic [11:0] C_NONE   = 12'h000;
    localparam logic [11:0] C_FWAIT  = 12'h800;
    localparam logic [11:0] C_FDONE  = 12'hB00;
    localparam logic [11:0] C_EX_R   = 12'h002;
    localparam logic [11:0] C_EX_I   = 12'h008;
    localparam logic [11:0] C_EX_BR  = 12'h081;
    localparam logic [11:0] C_MEM_LD = 12'hC48;
    localparam logic [11:0] C_MEM_ST = 12'hC18;
    localparam logic [11:0] C_WB_R   = 12'h004;
    localparam logic [11:0] C_WB_LD  = 12'h024;

    logic [11:0] ctl;
    assign ctl = {mem_req, mem_addr_sel, ir_write, pc_write, branch, mem_read,
                  mem_to_reg, mem_write, alu_src, reg_write_en, alu_op};

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_code      (op_code),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .branch       (branch),
        .mem_read     (mem_read),
        .mem_to_reg   (mem_to_reg),
        .mem_write    (mem_write),
        .alu_src      (alu_src),
        .reg_write_en (reg_write_en),
        .alu_op       (alu_op),
        .illegal      (illegal),
        .timeout      (timeout),
        .state        (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .instret      (instret),
        .cycles       (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the negedge, check, move to next negedge.
    task automatic step(input string tag, input logic rdy, input logic [6:0] op,
                        input logic [2:0] exp_state, input logic [11:0] exp_ctl,
                        input logic [1:0] exp_flags);
        mem_ready = rdy;
        op_code   = op;
        #1;
        check({tag, "/state"}, 32'(state), 32'(exp_state));
        check({tag, "/ctl"},   32'(ctl),   32'(exp_ctl));
        check({tag, "/flags"}, 32'({illegal, timeout}), 32'(exp_flags));
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        op_code   = 7'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state and R-type with zero waits: 0,1,2,4 then FETCH.
`ifdef MC_CTRL_PERF_EN
        check("perf_reset_instret", instret, 32'd0);
        check("perf_reset_cycles",  cycles,  32'd0);
`endif
        step("r_fetch",  1'b1, R, 3'd0, C_FDONE, 2'b00);
        step("r_decode", 1'b1, R, 3'd1, C_NONE,  2'b00);
        step("r_exec",   1'b1, R, 3'd2, C_EX_R,  2'b00);
        step("r_wb",     1'b1, R, 3'd4, C_WB_R,  2'b00);
`ifdef MC_CTRL_PERF_EN
        #1;
        check("perf_r_instret", instret, 32'd1);
        check("perf_r_cycles",  cycles,  32'd4);
`endif

        // I-ALU: same flow, different EXEC controls.
        step("i_fetch",  1'b1, IA, 3'd0, C_FDONE, 2'b00);
        step("i_decode", 1'b1, IA, 3'd1, C_NONE,  2'b00);
        step("i_exec",   1'b1, IA, 3'd2, C_EX_I,  2'b00);
        step("i_wb",     1'b1, IA, 3'd4, C_WB_R,  2'b00);

        // Load with 3 wait cycles; completion on the limit cycle wins over the trap.
        step("ld_fetch",  1'b1, LD, 3'd0, C_FDONE,  2'b00);
        step("ld_decode", 1'b1, LD, 3'd1, C_NONE,   2'b00);
        step("ld_exec",   1'b0, LD, 3'd2, C_EX_I,   2'b00);
        step("ld_mem0",   1'b0, LD, 3'd3, C_MEM_LD, 2'b00);
        step("ld_mem1",   1'b0, LD, 3'd3, C_MEM_LD, 2'b00);
        step("ld_mem2",   1'b0, LD, 3'd3, C_MEM_LD, 2'b00);
        step("ld_mem3",   1'b1, LD, 3'd3, C_MEM_LD, 2'b00);
        step("ld_wb",     1'b1, LD, 3'd4, C_WB_LD,  2'b00);

        // Store then branch: 4 + 3 cycles.
        step("st_fetch",  1'b1, ST, 3'd0, C_FDONE,  2'b00);
        step("st_decode", 1'b1, ST, 3'd1, C_NONE,   2'b00);
        step("st_exec",   1'b1, ST, 3'd2, C_EX_I,   2'b00);
        step("st_mem",    1'b1, ST, 3'd3, C_MEM_ST, 2'b00);
        step("br_fetch",  1'b1, BR, 3'd0, C_FDONE,  2'b00);
        step("br_decode", 1'b1, BR, 3'd1, C_NONE,   2'b00);
        step("br_exec",   1'b1, BR, 3'd2, C_EX_BR,  2'b00);

        // FETCH ready on the 4th request cycle: no trap.
        step("fw_0",      1'b0, R, 3'd0, C_FWAIT, 2'b00);
        step("fw_1",      1'b0, R, 3'd0, C_FWAIT, 2'b00);
        step("fw_2",      1'b0, R, 3'd0, C_FWAIT, 2'b00);
        step("fw_3",      1'b1, R, 3'd0, C_FDONE, 2'b00);
        step("fw_decode", 1'b0, R, 3'd1, C_NONE,  2'b00);
        step("fw_exec",   1'b0, R, 3'd2, C_EX_R,  2'b00);
        step("fw_wb",     1'b0, R, 3'd4, C_WB_R,  2'b00);

        // FETCH never ready: trap after 4 cycles, sticky timeout.
        step("to_0",    1'b0, R, 3'd0, C_FWAIT, 2'b00);
        step("to_1",    1'b0, R, 3'd0, C_FWAIT, 2'b00);
        step("to_2",    1'b0, R, 3'd0, C_FWAIT, 2'b00);
        step("to_3",    1'b0, R, 3'd0, C_FWAIT, 2'b00);
        step("to_trap", 1'b1, R, 3'd5, C_NONE,  2'b01);
        step("to_hold", 1'b1, R, 3'd5, C_NONE,  2'b01);
        pulse_rst();
        step("to_rst",  1'b1, BAD, 3'd0, C_FDONE, 2'b00);

        // Illegal opcode: TRAP after DECODE, stays until reset.
        step("ill_decode", 1'b1, BAD, 3'd1, C_NONE, 2'b00);
        step("ill_trap0",  1'b1, BAD, 3'd5, C_NONE, 2'b10);
        step("ill_trap1",  1'b0, R,   3'd5, C_NONE, 2'b10);
        step("ill_trap2",  1'b1, R,   3'd5, C_NONE, 2'b10);
        pulse_rst();
        step("ill_rst",    1'b0, R, 3'd0, C_FWAIT, 2'b00);
        pulse_rst();

        // Reset mid-MEM of a load: back to FETCH, no WB.
        step("mr_fetch",  1'b1, LD, 3'd0, C_FDONE,  2'b00);
        step("mr_decode", 1'b1, LD, 3'd1, C_NONE,   2'b00);
        step("mr_exec",   1'b0, LD, 3'd2, C_EX_I,   2'b00);
        step("mr_mem",    1'b0, LD, 3'd3, C_MEM_LD, 2'b00);
        pulse_rst();
`ifdef MC_CTRL_PERF_EN
        #1;
        check("perf_mr_instret", instret, 32'd0);
        check("perf_mr_cycles",  cycles,  32'd0);
`endif
        step("mr_after",  1'b0, R, 3'd0, C_FWAIT, 2'b00);
        step("mr_fetch2", 1'b1, R, 3'd0, C_FDONE, 2'b00);
        step("mr_decode2", 1'b1, R, 3'd1, C_NONE, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
